// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_ctrl_pkg
//  Description : Shared types and constants for the FIR sample sequencer.
//                Holds the FSM state encoding, the config address map and
//                the width of the dropped-sample counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_ctrl_pkg;

    // Sequencer states: wait for work, strobe the FIR, count down to result
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Config address map (address 3 is accepted and ignored)
    localparam logic [1:0] CFG_B0  = 2'd0;
    localparam logic [1:0] CFG_B1  = 2'd1;
    localparam logic [1:0] CFG_CLR = 2'd2;

    // Width of the dropped-sample counter
    localparam int OVF_CNT_W = 16;

endpackage : fir_ctrl_pkg
`default_nettype wire

// File: rtl/fir_ctrl_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fir_ctrl_fifo
//  Description : First-word-fall-through sample FIFO. The head entry is
//                visible on o_rdata whenever o_empty is low. A push and a pop
//                in the same cycle are both honoured, even when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_ctrl_fifo #(
    parameter int N      = 16,
    parameter int FDEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [N-1:0] i_wdata,
    input  logic         i_pop,
    output logic [N-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

    logic [N-1:0]  r_mem [FDEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Storage array; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(FDEPTH));
    assign o_empty = (r_count == '0);

endmodule : fir_ctrl_fifo
`default_nettype wire

// File: rtl/fir_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fir_ctrl
//  Description : Sample-rate sequencer and coefficient manager for a single
//                shared FIR. Buffers ADC samples, strobes the FIR only when
//                it is idle, captures each result, and commits shadow
//                coefficients only between computations.
//                Build option FIR_CTRL_OVF_CNT_EN: when defined, the
//                saturating dropped-sample counter is built; otherwise
//                ovf_cnt is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int N      = 16,
    parameter int LAT    = 6,
    parameter int FDEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [N-1:0]         in_data,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_addr,
    input  logic [N-1:0]         cfg_wdata,
    output logic                 fir_en,
    output logic [N-1:0]         fir_x,
    output logic [N-1:0]         fir_b0,
    output logic [N-1:0]         fir_b1,
    input  logic [N-1:0]         fir_y,
    output logic                 out_valid,
    output logic [N-1:0]         out_data,
    output logic                 busy,
    output logic                 ovf,
    output logic [OVF_CNT_W-1:0] ovf_cnt
);

    localparam int WCW = $clog2(LAT + 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [WCW-1:0] r_wcnt;
    logic [N-1:0]   r_fir_x;
    logic [N-1:0]   r_b0;
    logic [N-1:0]   r_b1;
    logic [N-1:0]   r_sh_b0;
    logic [N-1:0]   r_sh_b1;
    logic           r_dirty;
    logic           r_out_valid;
    logic [N-1:0]   r_out_data;
    logic           r_ovf;

    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [N-1:0]   w_head;
    logic           w_drop;
    logic           w_clr;
    logic           w_wr_b0;
    logic           w_wr_b1;
    logic           w_commit;
    logic           w_capture;

    // A full FIFO still accepts a sample when the head leaves this cycle
    assign w_pop     = (r_state == ST_ISSUE);
    assign w_push    = in_valid && (!w_full || w_pop);
    assign w_drop    = in_valid && !w_push;
    assign w_clr     = cfg_we && (cfg_addr == CFG_CLR);
    assign w_wr_b0   = cfg_we && (cfg_addr == CFG_B0);
    assign w_wr_b1   = cfg_we && (cfg_addr == CFG_B1);
    assign w_capture = (r_state == ST_WAIT) && (r_wcnt == WCW'(1));

    fir_ctrl_fifo #(
        .N      (N),
        .FDEPTH (FDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; a pending commit takes priority over issuing a sample, and
    // a sample arriving this cycle counts as work so the FIR starts next cycle
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_dirty) begin
                    w_commit = 1'b1;
                end else if (!w_empty || w_push) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wcnt == WCW'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Issue-side datapath: latch the presented sample and run the countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fir_x <= '0;
            r_wcnt  <= '0;
        end else if (w_pop) begin
            r_fir_x <= w_head;
            r_wcnt  <= WCW'(LAT - 1);
        end else if (r_state == ST_WAIT) begin
            r_wcnt  <= r_wcnt - 1'b1;
        end
    end

    // Result capture; out_data holds between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_capture;
            if (w_capture) begin
                r_out_data <= fir_y;
            end
        end
    end

    // Shadow coefficients and commit; a write racing a commit stays pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_b0 <= '0;
            r_sh_b1 <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_dirty <= 1'b0;
        end else begin
            if (w_commit) begin
                r_b0 <= r_sh_b0;
                r_b1 <= r_sh_b1;
            end
            if (w_wr_b0) begin
                r_sh_b0 <= cfg_wdata;
            end
            if (w_wr_b1) begin
                r_sh_b1 <= cfg_wdata;
            end
            if (w_wr_b0 || w_wr_b1) begin
                r_dirty <= 1'b1;
            end else if (w_commit) begin
                r_dirty <= 1'b0;
            end
        end
    end

    // Sticky overflow flag; a drop beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_clr) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef FIR_CTRL_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] r_ovf_cnt;

    // Saturating dropped-sample counter; a drop with a clear restarts at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (w_drop) begin
            if (w_clr) begin
                r_ovf_cnt <= OVF_CNT_W'(1);
            end else if (r_ovf_cnt != '1) begin
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
        end else if (w_clr) begin
            r_ovf_cnt <= '0;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`else
    assign ovf_cnt = '0;
`endif

    // fir_x shows the FIFO head while strobing and holds the last sample after
    assign fir_en    = w_pop;
    assign fir_x     = w_pop ? w_head : r_fir_x;
    assign fir_b0    = r_b0;
    assign fir_b1    = r_b1;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != ST_IDLE) || !w_empty;
    assign ovf       = r_ovf;

endmodule : fir_ctrl
`default_nettype wire

// File: tb/tb_fir_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_ctrl
//  Description : Scoreboard bench for fir_ctrl. Stimulus queues the expected
//                samples and strobe cycles; a monitor checks each fir_en and
//                out_valid against them. fir_y follows a cycle counter so
//                the capture cycle is visible in out_data.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fir_ctrl;
    import fir_ctrl_pkg::*;

    localparam int N      = 16;
    localparam int LAT    = 6;
    localparam int FDEPTH = 4;

`ifdef FIR_CTRL_OVF_CNT_EN
    localparam logic [15:0] c_CNT_ONE = 16'd1;
`else
    localparam logic [15:0] c_CNT_ONE = 16'd0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [N-1:0]         in_data;
    logic                 cfg_we;
    logic [1:0]           cfg_addr;
    logic [N-1:0]         cfg_wdata;
    logic                 fir_en;
    logic [N-1:0]         fir_x;
    logic [N-1:0]         fir_b0;
    logic [N-1:0]         fir_b1;
    logic [N-1:0]         fir_y;
    logic                 out_valid;
    logic [N-1:0]         out_data;
    logic                 busy;
    logic                 ovf;
    logic [OVF_CNT_W-1:0] ovf_cnt;

    fir_ctrl #(.N(N), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .fir_en    (fir_en),
        .fir_x     (fir_x),
        .fir_b0    (fir_b0),
        .fir_b1    (fir_b1),
        .fir_y     (fir_y),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .ovf       (ovf),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIR stand-in: result value identifies the cycle it was presented in
    assign fir_y = cyc[15:0] ^ 16'h5A00;

    typedef struct {
        int           cyc;
        logic [N-1:0] data;
    } res_t;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [N-1:0] sq[$];
    int           iq[$];
    res_t         rq[$];
    int           m_e;
    res_t         m_r;
    int           c;

    logic [N-1:0] burst [6] = '{16'h1111, 16'h8001, 16'h7FFF, 16'hFFFF, 16'h0042, 16'hDEAD};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: DUT event with no expectation queued (cycle %0d)", name, cyc);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fir_en"},    32'(fir_en),    32'h0);
        chk({tag, "_fir_x"},     32'(fir_x),     32'h0);
        chk({tag, "_fir_b0"},    32'(fir_b0),    32'h0);
        chk({tag, "_fir_b1"},    32'(fir_b1),    32'h0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_out_data"},  32'(out_data),  32'h0);
        chk({tag, "_busy"},      32'(busy),      32'h0);
        chk({tag, "_ovf"},       32'(ovf),       32'h0);
        chk({tag, "_ovf_cnt"},   32'(ovf_cnt),   32'h0);
    endtask

    // Six samples on consecutive cycles starting now; the last one is dropped
    task automatic run_burst(input logic clr_on_drop);
        c = cyc;
        for (int k = 0; k < 5; k++) begin
            iq.push_back(c + 1 + k * (LAT + 1));
            sq.push_back(burst[k]);
        end
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = burst[k];
            if (k == 5 && clr_on_drop) begin
                cfg_we   = 1'b1;
                cfg_addr = CFG_CLR;
            end
            step();
        end
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    // Monitor: check strobes against queued expectations, predict results
    always @(negedge clk) begin
        if (!rst) begin
            if (fir_en) begin
                if (iq.size() == 0) begin
                    miss("fir_en_cycle");
                end else begin
                    m_e = iq.pop_front();
                    chk("fir_en_cycle", cyc, m_e);
                end
                if (sq.size() == 0) begin
                    miss("fir_x");
                end else begin
                    chk("fir_x", 32'(fir_x), 32'(sq.pop_front()));
                end
                m_r.cyc  = cyc + LAT;
                m_r.data = 16'(cyc + LAT - 1) ^ 16'h5A00;
                rq.push_back(m_r);
            end
            if (out_valid) begin
                if (rq.size() == 0) begin
                    miss("out_valid");
                end else begin
                    m_r = rq.pop_front();
                    chk("out_valid_cycle", cyc, m_r.cyc);
                    chk("out_data", 32'(out_data), 32'(m_r.data));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        step(3);
        chk_all_zero("reset");
        rst = 1'b0;
        step(2);

        // Single sample: strobe next cycle, result LAT cycles after strobe
        c = cyc;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        sq.push_back(16'h1234);
        iq.push_back(c + 1);
        step();
        in_valid = 1'b0;
        chk("single_busy", 32'(busy), 32'h1);
        step(8);
        chk("single_busy_done", 32'(busy), 32'h0);
        chk("single_out_hold", 32'(out_data), 32'(16'(c + 6) ^ 16'h5A00));
        chk("single_fir_x_hold", 32'(fir_x), 32'h1234);

        // Burst of six into a four-deep FIFO
        step();
        run_burst(1'b0);
        chk("burst_ovf", 32'(ovf), 32'h1);
        chk("burst_ovf_cnt", 32'(ovf_cnt), 32'(c_CNT_ONE));
        step(35);

        // Coefficient write during WAIT commits at the next IDLE
        c = cyc;
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        sq.push_back(16'h7FFF);
        iq.push_back(c + 1);
        step();
        in_valid = 1'b0;
        step(2);
        cfg_we    = 1'b1;
        cfg_addr  = CFG_B0;
        cfg_wdata = 16'h4000;
        step();
        cfg_we   = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hC0DE;
        sq.push_back(16'hC0DE);
        iq.push_back(c + 9);
        chk("b0_held_wait", 32'(fir_b0), 32'h0);
        step();
        in_valid = 1'b0;
        step(2);
        chk("b0_held_idle", 32'(fir_b0), 32'h0);
        step();
        chk("b0_committed", 32'(fir_b0), 32'h4000);
        chk("b1_unchanged", 32'(fir_b1), 32'h0);
        step(14);

        // Clear racing a drop: drop wins and the count restarts at one
        run_burst(1'b1);
        chk("clrdrop_ovf", 32'(ovf), 32'h1);
        chk("clrdrop_ovf_cnt", 32'(ovf_cnt), 32'(c_CNT_ONE));
        step(35);
        cfg_we   = 1'b1;
        cfg_addr = CFG_CLR;
        step();
        cfg_we = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'h0);
        chk("clr_ovf_cnt", 32'(ovf_cnt), 32'h0);
        step(2);

        // Reset three cycles after the strobe discards the result
        c = cyc;
        in_valid = 1'b1;
        in_data  = 16'h0F0F;
        sq.push_back(16'h0F0F);
        iq.push_back(c + 1);
        step();
        in_valid = 1'b0;
        step(3);
        rst = 1'b1;
        rq.delete();
        step();
        rst = 1'b0;
        chk_all_zero("midreset");
        step(12);

        // Drain with a bound, then confirm nothing is left outstanding
        for (int i = 0; i < 100; i++) begin
            if (iq.size() == 0 && sq.size() == 0 && rq.size() == 0) break;
            step();
        end
        chk("left_issue", 32'(iq.size()), 32'h0);
        chk("left_sample", 32'(sq.size()), 32'h0);
        chk("left_result", 32'(rq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fir_ctrl
`default_nettype wire
